// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU control slice.
//   Opcode / funct3 constants, every decinst operation code, the controller
//   state enum and a helper that recognises a supported decinst code.
package alu_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // decinst = {sub/sra bit, srai bit, funct3, opcode}
  localparam logic [11:0] DEC_ADDI  = 12'h013;
  localparam logic [11:0] DEC_SLLI  = 12'h093;
  localparam logic [11:0] DEC_SLTI  = 12'h113;
  localparam logic [11:0] DEC_SLTIU = 12'h193;
  localparam logic [11:0] DEC_XORI  = 12'h213;
  localparam logic [11:0] DEC_SRLI  = 12'h293;
  localparam logic [11:0] DEC_SRAI  = 12'h693;
  localparam logic [11:0] DEC_ORI   = 12'h313;
  localparam logic [11:0] DEC_ANDI  = 12'h393;
  localparam logic [11:0] DEC_ADD   = 12'h033;
  localparam logic [11:0] DEC_SUB   = 12'h833;
  localparam logic [11:0] DEC_SLL   = 12'h0B3;
  localparam logic [11:0] DEC_SLT   = 12'h133;
  localparam logic [11:0] DEC_SLTU  = 12'h1B3;
  localparam logic [11:0] DEC_XOR   = 12'h233;
  localparam logic [11:0] DEC_SRL   = 12'h2B3;
  localparam logic [11:0] DEC_SRA   = 12'hAB3;
  localparam logic [11:0] DEC_OR    = 12'h333;
  localparam logic [11:0] DEC_AND   = 12'h3B3;
  localparam logic [11:0] DEC_BEQ   = 12'h063;
  localparam logic [11:0] DEC_BNE   = 12'h0E3;
  localparam logic [11:0] DEC_BLT   = 12'h263;
  localparam logic [11:0] DEC_BGE   = 12'h2E3;
  localparam logic [11:0] DEC_BLTU  = 12'h363;
  localparam logic [11:0] DEC_BGEU  = 12'h3E3;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    LOAD,
    SHIFT,
    OUTW,
    DONE
  } state_t;

  function automatic logic is_known_dec(input logic [11:0] d);
    case (d)
      DEC_ADDI, DEC_SLLI, DEC_SLTI, DEC_SLTIU, DEC_XORI, DEC_SRLI, DEC_SRAI,
      DEC_ORI, DEC_ANDI, DEC_ADD, DEC_SUB, DEC_SLL, DEC_SLT, DEC_SLTU,
      DEC_XOR, DEC_SRL, DEC_SRA, DEC_OR, DEC_AND, DEC_BEQ, DEC_BNE,
      DEC_BLT, DEC_BGE, DEC_BLTU, DEC_BGEU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec -- combinational RV32I OP / OP-IMM / BRANCH decoder.
//   inst      : instruction word
//   decinst   : ALU operation code (raw mapping, qualified by legal)
//   imm       : immediate operand (sign/zero extended per format)
//   is_shift  : legal shift operation (uses the multi-cycle shifter)
//   is_branch : legal branch (no write-back)
//   legal     : instruction is supported
module alu_dec
  import alu_pkg::*;
(
  input  logic [31:0] inst,
  output logic [11:0] decinst,
  output logic [31:0] imm,
  output logic        is_shift,
  output logic        is_branch,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       shamt_op;
  logic       f7_check;
  logic       f7_ok;
  logic       unused_rs1;

  assign unused_rs1 = ^inst[19:15];

  always_comb begin
    opcode   = inst[6:0];
    funct3   = inst[14:12];
    decinst  = {inst[30] & (opcode == OPC_OP),
                inst[30] & (opcode == OPC_OP_IMM) & (funct3 == F3_SR),
                funct3, opcode};
    shamt_op = (funct3 == F3_SLL) || (funct3 == F3_SR);
    f7_check = (opcode == OPC_OP) || ((opcode == OPC_OP_IMM) && shamt_op);
    // funct7 may only be 0x00, or 0x20 when that bit selects sub/sra/srai;
    // slli with inst[30] maps onto a valid code, so the bit must be vetted here.
    f7_ok     = ({inst[31], inst[29:25]} == '0) &&
                (!inst[30] || decinst[11] || decinst[10]);
    legal     = is_known_dec(decinst) && (!f7_check || f7_ok);
    is_shift  = legal && ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) && shamt_op;
    is_branch = legal && (opcode == OPC_BRANCH);

    imm = '0;
    case (opcode)
      OPC_OP_IMM: imm = shamt_op ? {27'b0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
      OPC_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      default:    imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl -- sequencing controller in front of a multi-cycle ALU.
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   inst/inst_valid   : instruction in; inst_ready high only in IDLE
//   decinst, imm      : registered operation code / immediate to the ALU
//   en, sl_ok         : shifter enable / shifter completion
//   cmp, carry        : ALU flags, captured into cmp_q / carry_q in DONE
//   done, wb_en       : completion pulse, write-back qualifier (non-branch)
//   illegal           : one-cycle pulse for unsupported instruction (or timeout)
// Parameter LAT (1..3): cycles from decinst valid to ALU result for non-shifts.
// Optional macro ALU_CTRL_TIMEOUT_EN: abort SHIFT after 40 cycles without sl_ok.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  output logic [11:0] decinst,
  output logic [31:0] imm,
  output logic        en,
  input  logic        sl_ok,
  input  logic        cmp,
  input  logic        carry,
  output logic        cmp_q,
  output logic        carry_q,
  output logic        done,
  output logic        wb_en,
  output logic        illegal
);

  logic [11:0] dec_w;
  logic [31:0] imm_w;
  logic        shift_w, branch_w, legal_w;

  alu_dec u_dec (
    .inst      (inst),
    .decinst   (dec_w),
    .imm       (imm_w),
    .is_shift  (shift_w),
    .is_branch (branch_w),
    .legal     (legal_w)
  );

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [11:0] dec_q, dec_d;
  logic [31:0] imm_q, imm_d;
  logic        shift_q, shift_d;
  logic        branch_q, branch_d;
  logic        wb_en_q, wb_en_d;
  logic        illegal_q, illegal_d;
  logic        cmp_d, carry_d;
`ifdef ALU_CTRL_TIMEOUT_EN
  logic [5:0]  to_q, to_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    imm_d     = imm_q;
    shift_d   = shift_q;
    branch_d  = branch_q;
    wb_en_d   = wb_en_q;
    cmp_d     = cmp_q;
    carry_d   = carry_q;
    illegal_d = 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
    to_d      = to_q;
`endif

    case (state_q)
      IDLE: begin
        if (inst_valid) begin
          if (legal_w) begin
            dec_d    = dec_w;
            imm_d    = imm_w;
            shift_d  = shift_w;
            branch_d = branch_w;
            cnt_d    = 2'(LAT - 1);
            state_d  = shift_w ? LOAD : EXEC;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d = cnt_q - 2'd1;
      end
      LOAD: begin
        state_d = SHIFT;
`ifdef ALU_CTRL_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      SHIFT: begin
        if (sl_ok) begin
          if (LAT == 1) begin
            state_d = DONE;
          end else begin
            state_d = OUTW;
            cnt_d   = 2'(LAT - 2);
          end
        end
`ifdef ALU_CTRL_TIMEOUT_EN
        else if (to_q == 6'd39) begin
          state_d   = IDLE;
          illegal_d = 1'b1;
          dec_d     = '0;
          imm_d     = '0;
          shift_d   = 1'b0;
          branch_d  = 1'b0;
        end else begin
          to_d = to_q + 6'd1;
        end
`endif
      end
      OUTW: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d = cnt_q - 2'd1;
      end
      DONE: begin
        // Flags are taken while DONE is showing, i.e. at the edge that leaves it.
        cmp_d    = cmp;
        carry_d  = carry;
        state_d  = IDLE;
        dec_d    = '0;
        imm_d    = '0;
        shift_d  = 1'b0;
        branch_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // wb_en is updated on entry so it is already valid during DONE.
    if (state_d == DONE) wb_en_d = !branch_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dec_q     <= '0;
      imm_q     <= '0;
      shift_q   <= 1'b0;
      branch_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      cmp_q     <= 1'b0;
      carry_q   <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      imm_q     <= imm_d;
      shift_q   <= shift_d;
      branch_q  <= branch_d;
      wb_en_q   <= wb_en_d;
      illegal_q <= illegal_d;
      cmp_q     <= cmp_d;
      carry_q   <= carry_d;
`ifdef ALU_CTRL_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign inst_ready = (state_q == IDLE) && !reset;
  assign decinst    = dec_q;
  assign imm        = imm_q;
  assign done       = (state_q == DONE);
  assign wb_en      = wb_en_q;
  assign illegal    = illegal_q;
  assign en         = (state_q == SHIFT) || (state_q == OUTW) ||
                      ((state_q == DONE) && shift_q);

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [11:0] decinst;
  logic [31:0] imm;
  logic        en;
  logic        sl_ok;
  logic        cmp, carry;
  logic        cmp_q, carry_q;
  logic        done, wb_en, illegal;

  alu_ctrl #(.LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .decinst    (decinst),
    .imm        (imm),
    .en         (en),
    .sl_ok      (sl_ok),
    .cmp        (cmp),
    .carry      (carry),
    .cmp_q      (cmp_q),
    .carry_q    (carry_q),
    .done       (done),
    .wb_en      (wb_en),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [11:0] dec;
    logic [31:0] imm;
    bit          legal;
    bit          shift;
    bit          branch;
    int unsigned sl_n;
    bit          cmp;
    bit          carry;
  } vec_t;

  vec_t vecs[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned done_cyc = 0, done_cnt = 0, en_cnt = 0, ill_cnt = 0, ill_cyc = 0, sl_seen = 0;
    bit          sl_given = 0;
    logic [11:0] dec1, dec_done = 'x, dec_after = 'x;
    logic [31:0] imm1;
    logic        en1, rdy1, wb_done = 'x, cmpq_after = 'x, carryq_after = 'x, en_after = 'x;
    int unsigned exp_done_cyc, exp_en;
    string       p;
    p = $sformatf("v%0d", idx);
    exp_done_cyc = !v.legal ? 0 : (v.shift ? v.sl_n + LAT + 1 : LAT + 1);
    exp_en       = v.shift ? v.sl_n + LAT : 0;

    chk({p, " ready_before"}, 32'(inst_ready), 32'd1);
    inst = v.inst; inst_valid = 1'b1; cmp = v.cmp; carry = v.carry;
    step();
    inst_valid = 1'b0; inst = '0;
    dec1 = decinst; imm1 = imm; en1 = en; rdy1 = inst_ready;
    for (int unsigned cyc = 1; cyc <= 30; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc; wb_done = wb_en; dec_done = decinst;
        end
      end
      if (illegal) begin ill_cnt++; ill_cyc = cyc; end
      if (en) en_cnt++;
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        cmpq_after = cmp_q; carryq_after = carry_q; dec_after = decinst; en_after = en;
      end
      sl_ok = 1'b0;
      if (v.shift && en && !sl_given) begin
        sl_seen++;
        if (sl_seen == v.sl_n) begin sl_ok = 1'b1; sl_given = 1; end
      end
      step();
    end
    sl_ok = 1'b0; cmp = 1'b0; carry = 1'b0;

    chk({p, " decinst"}, 32'(dec1), v.legal ? 32'(v.dec) : 32'd0);
    chk({p, " imm"}, imm1, v.legal ? v.imm : 32'd0);
    chk({p, " en_first"}, 32'(en1), 32'd0);
    chk({p, " ready_busy"}, 32'(rdy1), v.legal ? 32'd0 : 32'd1);
    chk({p, " done_cycle"}, done_cyc, exp_done_cyc);
    chk({p, " done_count"}, done_cnt, v.legal ? 32'd1 : 32'd0);
    chk({p, " en_cycles"}, en_cnt, exp_en);
    chk({p, " illegal_count"}, ill_cnt, v.legal ? 32'd0 : 32'd1);
    chk({p, " illegal_cycle"}, ill_cyc, v.legal ? 32'd0 : 32'd1);
    if (v.legal) begin
      chk({p, " dec_at_done"}, 32'(dec_done), 32'(v.dec));
      chk({p, " wb_en"}, 32'(wb_done), v.branch ? 32'd0 : 32'd1);
      chk({p, " cmp_q"}, 32'(cmpq_after), 32'(v.cmp));
      chk({p, " carry_q"}, 32'(carryq_after), 32'(v.carry));
      chk({p, " dec_idle"}, 32'(dec_after), 32'd0);
      chk({p, " en_idle"}, 32'(en_after), 32'd0);
      chk({p, " wb_en_hold"}, 32'(wb_en), v.branch ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    int unsigned c1, c2;
    logic [11:0] d1, d2;

    //               inst           dec      imm           leg shf br sl cmp cry
    vecs[0]  = '{32'h00500093, 12'h013, 32'h00000005, 1, 0, 0, 0, 0, 1};
    vecs[1]  = '{32'h403100B3, 12'h833, 32'h00000000, 1, 0, 0, 0, 1, 0};
    vecs[2]  = '{32'h4070D093, 12'h693, 32'h00000007, 1, 1, 0, 5, 0, 1};
    vecs[3]  = '{32'h00209463, 12'h0E3, 32'h00000008, 1, 0, 1, 0, 1, 0};
    vecs[4]  = '{32'h0000007F, 12'h000, 32'h00000000, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{32'hFFF00093, 12'h013, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{32'h003110B3, 12'h0B3, 32'h00000000, 1, 1, 0, 1, 1, 1};
    vecs[7]  = '{32'h01F09093, 12'h093, 32'h0000001F, 1, 1, 0, 2, 0, 0};
    vecs[8]  = '{32'h41F09093, 12'h000, 32'h00000000, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{32'h40004033, 12'h000, 32'h00000000, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{32'hFE000EE3, 12'h063, 32'hFFFFFFFC, 1, 0, 1, 0, 0, 1};
    vecs[11] = '{32'h02000033, 12'h000, 32'h00000000, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{32'h00002063, 12'h000, 32'h00000000, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{32'h80007093, 12'h393, 32'hFFFFF800, 1, 0, 0, 0, 1, 1};
    vecs[14] = '{32'h40005033, 12'hAB3, 32'h00000000, 1, 1, 0, 3, 1, 0};

    reset = 1'b1; inst = '0; inst_valid = 1'b0; sl_ok = 1'b0; cmp = 1'b0; carry = 1'b0;
    step(); step();
    chk("rst inst_ready", 32'(inst_ready), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst en", 32'(en), 32'd0);
    chk("rst decinst", 32'(decinst), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst wb_en", 32'(wb_en), 32'd0);
    reset = 1'b0;
    step();
    chk("post-rst inst_ready", 32'(inst_ready), 32'd1);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Source keeps inst_valid high while busy; the second instruction must wait.
    c1 = 0; c2 = 0; d1 = '0; d2 = '0;
    inst = vecs[0].inst; inst_valid = 1'b1;
    step();
    inst = vecs[1].inst;
    chk("hold ready_busy", 32'(inst_ready), 32'd0);
    for (int unsigned cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == LAT + 3) inst_valid = 1'b0;
      if (done) begin
        if (c1 == 0) begin c1 = cyc; d1 = decinst; end
        else if (c2 == 0) begin c2 = cyc; d2 = decinst; end
      end
      step();
    end
    inst_valid = 1'b0;
    chk("hold done1_cycle", c1, LAT + 1);
    chk("hold done1_dec", 32'(d1), 32'h013);
    chk("hold done2_cycle", c2, 2 * LAT + 3);
    chk("hold done2_dec", 32'(d2), 32'h833);

    // Reset asserted mid-cycle while in SHIFT.
    inst = vecs[2].inst; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    step(); step();
    chk("rsh en_in_shift", 32'(en), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("rsh en", 32'(en), 32'd0);
    chk("rsh decinst", 32'(decinst), 32'd0);
    chk("rsh done", 32'(done), 32'd0);
    chk("rsh imm", imm, 32'd0);
    #1 reset = 1'b0;
    step();
    chk("rsh no_done", 32'(done), 32'd0);
    run_vec(100, vecs[0]);

`ifdef ALU_CTRL_TIMEOUT_EN
    begin
      int unsigned ic = 0, dn = 0;
      inst = vecs[2].inst; inst_valid = 1'b1;
      step();
      inst_valid = 1'b0; sl_ok = 1'b0;
      for (int unsigned cyc = 1; cyc <= 50; cyc++) begin
        if (illegal && ic == 0) ic = cyc;
        if (done) dn++;
        step();
      end
      chk("timeout illegal_cycle", ic, 32'd42);
      chk("timeout no_done", dn, 32'd0);
      chk("timeout en", 32'(en), 32'd0);
      chk("timeout ready", 32'(inst_ready), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
